uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receive core of the UART peripheral. It synchronises the asynchronous rx pin and oversamples it 16x from a programmable tick. It de-frames 8N1 characters (optional parity) LSB-first. Each received byte goes out on a valid/ready interface that feeds the peripheral's RX FIFO. Framing and overrun events go out as single-cycle pulses that the peripheral folds into its status and interrupt registers.

Parameters:
DATA_BITS, 8, data bits per character (5..8)
DIV_WIDTH, 16, width of baud divisor input
OVERSAMPLE, 16, ticks per bit period (fixed 16; parameter exists for package consistency only)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-high
en  in  1  receiver enable (CTRL RX enable bit)
baud_div  in  DIV_WIDTH  oversample tick period = baud_div+1 clk cycles
parity_en  in  1  expect parity bit after data (used only with UART_RX_PARITY_EN)
parity_odd  in  1  1 = odd parity, 0 = even (used only with UART_RX_PARITY_EN)
rx_pin  in  1  asynchronous serial input, idle high
data_out  out  DATA_BITS  received byte, stable while valid
valid  out  1  data_out holds an unread byte
ready  in  1  consumer (RX FIFO) accepts byte when valid&&ready
busy  out  1  frame in progress (state != IDLE)
frame_err  out  1  1-cycle pulse: stop bit sampled low
parity_err  out  1  1-cycle pulse: parity mismatch
overrun  out  1  1-cycle pulse: byte completed while valid still high

Behaviour:
- Reset values: data_out=0, valid=0, busy=0, frame_err=0, parity_err=0, overrun=0. Both synchroniser flops reset to 1, tick counter to 0, state to IDLE.
- Synchroniser: 2 flops; every use of rx below means the synchronised value (2-cycle input latency).
- Tick generator: a down-counter reloads baud_div and pulses tick for one clk on reaching 0. baud_div=0 gives a tick every clk. A baud_div change takes effect at the next reload. The counter free-runs in IDLE.
- Bit phase counter: 4 bits, counts ticks and wraps 15->0. On start detection it is cleared to 0. The sample point is phase 7, i.e. the 8th tick.
- Majority vote: rx is captured at phases 6, 7 and 8. Bit value = majority of the three, decided at phase 8.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: armed only after a tick has seen rx=1. On a tick with rx=0 while armed -> START, phase cleared.
- START: at the phase-8 decision, vote=1 means a glitch -> IDLE. Vote=0 -> DATA at phase wrap, bit index 0.
- DATA: the vote is shifted in LSB-first. After DATA_BITS bits -> PARITY if parity active, else STOP.
- PARITY: the vote is compared with the XOR of the data bits, inverted if odd.
- STOP: decided at the phase-8 vote, then -> IDLE immediately (half-bit early resync), disarmed until rx=1 is seen.
  - Stop bit 0: frame_err pulses, parity_err is not raised, byte discarded.
  - Stop bit 1, parity mismatch: parity_err pulses, byte discarded.
  - Stop bit 1, otherwise: byte delivered.
- Delivery:
  - valid=0: data_out is loaded and valid=1 on the clk after the decision.
  - valid=1 and ready=0: overrun pulses, new byte dropped, old byte kept.
  - valid=1 and ready=1 in the delivery cycle: the handshake completes and the new byte loads, so no overrun.
- valid clears on the clk after valid&&ready.
- en=0: state forced to IDLE and disarmed next clk; any in-flight frame is aborted with no pulses. valid and data_out are untouched and the handshake still works.
- Break (rx low indefinitely): exactly one frame_err, then the receiver stays disarmed until rx goes high.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the PARITY state exists, parity_en and parity_odd are honoured, and parity_err is driven as above.
- Undefined: the PARITY state is not built, parity_en and parity_odd are ignored, and parity_err is tied to 0. Ports are identical in both builds.

Decomposition:
- uart_pkg:
  - uart_rx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - localparams OVERSAMPLE=16, SAMPLE_MID=7
  - vote helper function maj3
- Sub-module uart_baud_tick: tick generator (clk, rst, en, baud_div -> tick). It is shared later with uart_tx.

Test Plan:
1. baud_div=0, en=1, send 0xA5 8N1 at 16 clk/bit -> valid rises once, data_out=0xA5, no error pulses. With ready held 1, valid lasts one cycle.
2. 3-clk low glitch on idle rx -> returns to IDLE, valid stays 0, busy pulses ≤10 cycles.
3. Send 0x3C with stop bit forced 0 -> frame_err pulses once, valid stays 0. Next frame 0x81 is received correctly after rx returns high.
4. ready=0, send 0x11 then 0x22 -> data_out=0x11, overrun pulses once at the second stop decision. Raising ready gives valid=0; next byte 0x33 is delivered.
5. baud_div=3, en dropped at bit 4 of 0x55, then re-enabled -> no valid, no pulses. Next frame 0x55 is received.
6. UART_RX_PARITY_EN, parity_en=1, parity_odd=0, send 0x07 with parity bit 0 -> parity_err pulse, byte dropped. Parity bit 1 -> data_out=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART cores
//
// Contents:
//   uart_rx_state_e  receiver FSM states
//   OVERSAMPLE       ticks per bit period
//   SAMPLE_MID       phase at which the centre sample is taken
//   maj3             2-of-3 majority vote
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator shared by the UART rx/tx cores
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   en        in   enable; while low the counter is held at 0 and no ticks occur
//   baud_div  in   tick period = baud_div+1 clk cycles
//   tick      out  one-clk pulse each time the down-counter reaches 0
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = en && (cnt == '0);

  // baud_div is only sampled at reload, so a new divisor takes effect on
  // the next period rather than truncating the current one.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= baud_div;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receive core: 16x oversampled 8N1 deframer with valid/ready output
//
// Optional feature macro: UART_RX_PARITY_EN (builds the parity state and parity_err).
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   en          in   receiver enable; low aborts any frame and disarms
//   baud_div    in   oversample tick period = baud_div+1 clk cycles
//   parity_en   in   expect a parity bit after the data bits (parity build only)
//   parity_odd  in   1 = odd parity, 0 = even (parity build only)
//   rx_pin      in   asynchronous serial input, idle high
//   data_out    out  received character, stable while valid
//   valid       out  data_out holds an unread character
//   ready       in   consumer accepts on valid && ready
//   busy        out  a frame is in progress
//   frame_err   out  1-clk pulse: stop bit sampled low
//   parity_err  out  1-clk pulse: parity mismatch (tied 0 without the parity build)
//   overrun     out  1-clk pulse: character completed while valid still high
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int PHASE_W = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PH_EARLY = PHASE_W'(SAMPLE_MID - 1);
  localparam logic [PHASE_W-1:0] PH_MID   = PHASE_W'(SAMPLE_MID);
  localparam logic [PHASE_W-1:0] PH_LATE  = PHASE_W'(SAMPLE_MID + 1);
  localparam logic [3:0]         LAST_BIT = 4'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 tick;
  uart_rx_state_e       state;
  logic                 armed;
  logic [PHASE_W-1:0]   phase;
  logic [PHASE_W-1:0]   ph_next;
  logic                 s_early;
  logic                 s_mid;
  logic                 vote;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`else
  logic                 parity_unused;
  assign parity_unused = parity_en ^ parity_odd;
  assign parity_err    = 1'b0;
`endif

  // Two-flop synchroniser; reset to the idle line level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
    end
  end

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // phase holds the index of the most recent tick; the detection tick is 0.
  assign ph_next = phase + 1'b1;
  // Third sample is the live synchronised value at the decision tick.
  assign vote    = maj3(s_early, s_mid, rx_sync);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      phase     <= '0;
      s_early   <= 1'b1;
      s_mid     <= 1'b1;
      bit_idx   <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      // Consumer handshake; a delivery in the same cycle overrides this below.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      if (!en) begin
        state <= IDLE;
        armed <= 1'b0;
      end else if (tick) begin
        if (state == IDLE) begin
          // Arming needs a high sample first so a line stuck low (break)
          // cannot retrigger frames back to back.
          if (rx_sync) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= START;
            phase <= '0;
          end
        end else begin
          phase <= ph_next;
          if (ph_next == PH_EARLY) s_early <= rx_sync;
          if (ph_next == PH_MID)   s_mid   <= rx_sync;
          if (ph_next == PH_LATE) begin
            case (state)
              START: begin
                if (vote) begin
                  state <= IDLE;
                end else begin
                  state   <= DATA;
                  bit_idx <= '0;
                end
              end
              DATA: begin
                shreg   <= {vote, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state <= parity_en ? PARITY : STOP;
`else
                  state <= STOP;
`endif
                end
              end
`ifdef UART_RX_PARITY_EN
              PARITY: begin
                par_bad <= vote != ((^shreg) ^ parity_odd);
                state   <= STOP;
              end
`endif
              STOP: begin
                // Return to IDLE mid stop bit so the next start edge is
                // caught even from a slightly fast transmitter.
                state <= IDLE;
                armed <= 1'b0;
                if (!vote) begin
                  frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                end else if (par_bad) begin
                  parity_err <= 1'b1;
`endif
                end else if (!valid || ready) begin
                  data_out <= shreg;
                  valid    <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                par_bad <= 1'b0;
`endif
              end
              default: state <= IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] baud_div = 16'd0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        rx_pin = 1'b1;
  logic [7:0]  data_out;
  logic        valid;
  logic        ready = 1'b1;
  logic        busy;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int bit_clks = 16;

  // Event counters maintained only by the monitor below.
  int   n_valid = 0;
  int   n_vcyc = 0;
  int   n_ferr = 0;
  int   n_perr = 0;
  int   n_ovr = 0;
  int   n_busy = 0;
  logic valid_d = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .rx_pin     (rx_pin),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always @(negedge clk) begin
    if (valid && !valid_d) begin
      n_valid   = n_valid + 1;
      prev_data = last_data;
      last_data = data_out;
    end
    valid_d = valid;
    if (valid)      n_vcyc = n_vcyc + 1;
    if (frame_err)  n_ferr = n_ferr + 1;
    if (parity_err) n_perr = n_perr + 1;
    if (overrun)    n_ovr  = n_ovr + 1;
    if (busy)       n_busy = n_busy + 1;
  end

  task automatic drive_bit(input logic b, input int n);
    rx_pin = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic with_par, input logic par_bit);
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks);
    if (with_par) drive_bit(par_bit, bit_clks);
    drive_bit(stop_bit, bit_clks);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({data_out, valid, busy, frame_err, parity_err, overrun} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {data_out, valid, busy, frame_err, parity_err, overrun});
    end
    rst = 1'b0;
    idle(32);
    tests++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_basic;
    int v0, c0, e0;
    v0 = n_valid; c0 = n_vcyc; e0 = n_ferr + n_perr + n_ovr;
    ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_valid - v0 !== 1) begin
      fails++; $display("FAIL basic_valid_count: got %0d expected 1", n_valid - v0);
    end
    tests++;
    if (last_data !== 8'hA5) begin
      fails++; $display("FAIL basic_data: got %h expected a5", last_data);
    end
    tests++;
    if (n_vcyc - c0 !== 1) begin
      fails++; $display("FAIL basic_valid_cycles: got %0d expected 1", n_vcyc - c0);
    end
    tests++;
    if (n_ferr + n_perr + n_ovr - e0 !== 0) begin
      fails++; $display("FAIL basic_no_errors: got %0d expected 0", n_ferr + n_perr + n_ovr - e0);
    end
  endtask

  task automatic test_glitch;
    int v0, b0, e0;
    v0 = n_valid; b0 = n_busy; e0 = n_ferr + n_ovr;
    drive_bit(1'b0, 3);
    idle(48);
    tests++;
    if (n_busy - b0 < 1 || n_busy - b0 > 10) begin
      fails++; $display("FAIL glitch_busy_cycles: got %0d expected 1..10", n_busy - b0);
    end
    tests++;
    if (n_valid - v0 !== 0 || n_ferr + n_ovr - e0 !== 0) begin
      fails++; $display("FAIL glitch_no_events: valid=%0d err=%0d expected 0 0",
                        n_valid - v0, n_ferr + n_ovr - e0);
    end
  endtask

  task automatic test_frame_error;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(32);
    tests++;
    if (n_ferr - f0 !== 1) begin
      fails++; $display("FAIL frame_err_count: got %0d expected 1", n_ferr - f0);
    end
    tests++;
    if (n_valid - v0 !== 0) begin
      fails++; $display("FAIL frame_err_discard: got %0d valids expected 0", n_valid - v0);
    end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_valid - v0 !== 1 || last_data !== 8'h81) begin
      fails++; $display("FAIL after_frame_err: valids=%0d data=%h expected 1 81",
                        n_valid - v0, last_data);
    end
  endtask

  task automatic test_overrun;
    int v0, o0;
    o0 = n_ovr;
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    idle(8);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (valid !== 1'b1 || data_out !== 8'h11) begin
      fails++; $display("FAIL overrun_keep_old: valid=%b data=%h expected 1 11", valid, data_out);
    end
    tests++;
    if (n_ovr - o0 !== 1) begin
      fails++; $display("FAIL overrun_count: got %0d expected 1", n_ovr - o0);
    end
    ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (valid !== 1'b0) begin
      fails++; $display("FAIL overrun_drain: valid=%b expected 0", valid);
    end
    v0 = n_valid;
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_valid - v0 !== 1 || last_data !== 8'h33 || n_ovr - o0 !== 1) begin
      fails++; $display("FAIL overrun_next: valids=%0d data=%h ovr=%0d expected 1 33 1",
                        n_valid - v0, last_data, n_ovr - o0);
    end
  endtask

  task automatic test_enable_abort;
    int v0, e0;
    logic [7:0] d;
    d = 8'h55;
    baud_div = 16'd3;
    bit_clks = 64;
    idle(128);
    v0 = n_valid; e0 = n_ferr + n_perr + n_ovr;
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 4; i++) drive_bit(d[i], bit_clks);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL abort_busy_before: got %b expected 1", busy);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL abort_busy_after: got %b expected 0", busy);
    end
    for (int i = 4; i < 8; i++) drive_bit(d[i], bit_clks);
    drive_bit(1'b1, bit_clks);
    en = 1'b1;
    idle(2 * bit_clks);
    tests++;
    if (n_valid - v0 !== 0 || n_ferr + n_perr + n_ovr - e0 !== 0) begin
      fails++; $display("FAIL abort_silent: valids=%0d err=%0d expected 0 0",
                        n_valid - v0, n_ferr + n_perr + n_ovr - e0);
    end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(bit_clks);
    tests++;
    if (n_valid - v0 !== 1 || last_data !== 8'h55) begin
      fails++; $display("FAIL abort_recover: valids=%0d data=%h expected 1 55",
                        n_valid - v0, last_data);
    end
    baud_div = 16'd0;
    bit_clks = 16;
    idle(64);
  endtask

  task automatic test_break;
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b0, 400);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL break_disarmed: busy=%b expected 0", busy);
    end
    idle(32);
    tests++;
    if (n_ferr - f0 !== 1 || n_valid - v0 !== 0) begin
      fails++; $display("FAIL break_single_err: ferr=%0d valids=%0d expected 1 0",
                        n_ferr - f0, n_valid - v0);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_valid - v0 !== 1 || last_data !== 8'h5A) begin
      fails++; $display("FAIL break_recover: valids=%0d data=%h expected 1 5a",
                        n_valid - v0, last_data);
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = n_valid;
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_valid - v0 !== 2 || prev_data !== 8'h12 || last_data !== 8'h34) begin
      fails++; $display("FAIL back_to_back: valids=%0d data=%h,%h expected 2 12,34",
                        n_valid - v0, prev_data, last_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(16);
    tests++;
    if (n_perr - p0 !== 1 || n_valid - v0 !== 0) begin
      fails++; $display("FAIL parity_bad: perr=%0d valids=%0d expected 1 0",
                        n_perr - p0, n_valid - v0);
    end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(16);
    tests++;
    if (n_perr - p0 !== 1 || n_valid - v0 !== 1 || last_data !== 8'h07) begin
      fails++; $display("FAIL parity_good: perr=%0d valids=%0d data=%h expected 1 1 07",
                        n_perr - p0, n_valid - v0, last_data);
    end
    parity_odd = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(16);
    tests++;
    if (n_perr - p0 !== 1 || n_valid - v0 !== 2) begin
      fails++; $display("FAIL parity_odd_good: perr=%0d valids=%0d expected 1 2",
                        n_perr - p0, n_valid - v0);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask
`else
  task automatic test_parity;
    int v0, p0;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle(16);
    tests++;
    if (n_perr - p0 !== 0 || n_valid - v0 !== 1 || last_data !== 8'h07) begin
      fails++; $display("FAIL parity_ignored: perr=%0d valids=%0d data=%h expected 0 1 07",
                        n_perr - p0, n_valid - v0, last_data);
    end
    parity_en = 1'b0;
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_enable_abort();
    test_break();
    test_back_to_back();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
